// File: rtl/control_fsm.sv
// Multi-cycle RV32I/RV64I control FSM: fetch, decode and sequence each
// instruction, driving datapath enables/selects and trapping on illegal
// encodings, ecall/ebreak and memory bus timeouts.
module control_fsm #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_OP_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         imem_rdata,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic [2:0]          mem_size,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          alu_src_a,
  output logic                ALU_imm,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                branch_enable,
  output logic [2:0]          branch_cond,
  output logic                jump,
  output logic                reg_write_enable,
  output logic [1:0]          rd_src,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  localparam bit IS64 = (XLEN == 64);

  // At least one counter bit even when the timeout is disabled.
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Value held during the last permitted wait cycle.
  localparam logic [CNT_W-1:0] CNT_LIM = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(9);

  localparam logic [1:0] SRC_RS1  = 2'd0;
  localparam logic [1:0] SRC_PC   = 2'd1;
  localparam logic [1:0] SRC_ZERO = 2'd2;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_ECALL   = 2'd1;
  localparam logic [1:0] CAUSE_IFETCH  = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                dec_illegal;
  logic                dec_system;
  logic                dec_imm;
  logic [1:0]          dec_src_a;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                is_load;
  logic                is_store;
  logic                is_branch;
  logic                is_jump;
  logic                is_fence;
  logic                timeout_hit;

  function automatic logic [ALU_OP_W-1:0] alu_fn(input logic [2:0] f3, input logic alt);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // State, instruction, wait-counter and trap-cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      ir_q    <= '0;
      cnt_q   <= '0;
      cause_q <= CAUSE_ILLEGAL;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Instruction classification and legality from the latched IR.
  always_comb begin
    opcode      = ir_q[6:0];
    funct3      = ir_q[14:12];
    funct7      = ir_q[31:25];
    dec_illegal = 1'b0;
    dec_system  = 1'b0;
    dec_imm     = 1'b0;
    dec_src_a   = SRC_RS1;
    dec_alu_op  = ALU_ADD;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    is_fence    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_imm   = 1'b1;
        dec_src_a = SRC_ZERO;
      end
      OPC_AUIPC: begin
        dec_imm   = 1'b1;
        dec_src_a = SRC_PC;
      end
      OPC_JAL: begin
        is_jump   = 1'b1;
        dec_imm   = 1'b1;
        dec_src_a = SRC_PC;
      end
      OPC_JALR: begin
        is_jump     = 1'b1;
        dec_imm     = 1'b1;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        is_branch   = 1'b1;
        dec_alu_op  = ALU_SUB;
        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        is_load = 1'b1;
        dec_imm = 1'b1;
        case (funct3)
          3'b011, 3'b110: dec_illegal = !IS64;
          3'b111:         dec_illegal = 1'b1;
          default:        dec_illegal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        is_store = 1'b1;
        dec_imm  = 1'b1;
        if (funct3 == 3'b011) begin
          dec_illegal = !IS64;
        end else begin
          dec_illegal = funct3[2];
        end
      end
      OPC_OP_IMM: begin
        dec_imm    = 1'b1;
        dec_alu_op = alu_fn(funct3, (funct3 == 3'b101) && ir_q[30]);
        // RV64 shifts borrow funct7[0] as shamt[5].
        if (funct3 == 3'b001) begin
          dec_illegal = IS64 ? (ir_q[31:26] != 6'b000000) : (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_illegal = IS64 ? ((ir_q[31:26] != 6'b000000) && (ir_q[31:26] != 6'b010000))
                             : ((funct7 != 7'b0000000) && (funct7 != 7'b0100000));
        end
      end
      OPC_OP: begin
        dec_alu_op  = alu_fn(funct3, ir_q[30]);
        dec_illegal = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_FENCE: begin
        is_fence    = 1'b1;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_SYSTEM: begin
        if ((ir_q == INSN_ECALL) || (ir_q == INSN_EBREAK)) begin
          dec_system = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LIM);

  // Next-state, Moore outputs and handshake-qualified strobes.
  always_comb begin
    state_d          = state_q;
    ir_d             = ir_q;
    cnt_d            = cnt_q;
    cause_d          = cause_q;
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    mem_size         = 3'b000;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    alu_src_a        = SRC_RS1;
    ALU_imm          = 1'b0;
    ALU_op           = ALU_ADD;
    branch_enable    = 1'b0;
    branch_cond      = 3'b000;
    jump             = 1'b0;
    reg_write_enable = 1'b0;
    rd_src           = 2'd0;
    trap             = 1'b0;
    trap_cause       = cause_q;

    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          ir_d     = imem_rdata;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          cause_d = CAUSE_IFETCH;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = S_TRAP;
        end else if (dec_system) begin
          cause_d = CAUSE_ECALL;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = dec_src_a;
        ALU_imm   = dec_imm;
        ALU_op    = dec_alu_op;
        state_d   = S_FETCH;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          branch_enable = 1'b1;
          branch_cond   = funct3;
          pc_write      = 1'b1;
        end else if (is_jump) begin
          jump             = 1'b1;
          reg_write_enable = 1'b1;
          rd_src           = 2'd2;
          pc_write         = 1'b1;
        end else if (is_fence) begin
          pc_write = 1'b1;
        end else begin
          reg_write_enable = 1'b1;
          pc_write         = 1'b1;
        end
      end
      S_MEM: begin
        // Keep the address computation driven so the ALU output stays stable.
        alu_src_a = dec_src_a;
        ALU_imm   = dec_imm;
        ALU_op    = dec_alu_op;
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        mem_size  = funct3;
        if (dmem_ack) begin
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          cause_d = CAUSE_DMEM;
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write_enable = 1'b1;
        rd_src           = 2'd1;
        pc_write         = 1'b1;
        state_d          = S_FETCH;
      end
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_BOOT;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_AND = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic        dmem_ack;
  logic [31:0] imem_rdata;

  always #5 clk = ~clk;

  logic       a_imem_req, a_dmem_req, a_dmem_we, a_ir_write, a_pc_write, a_ALU_imm;
  logic       a_branch_enable, a_jump, a_reg_write_enable, a_trap;
  logic [2:0] a_mem_size, a_branch_cond;
  logic [1:0] a_alu_src_a, a_rd_src, a_trap_cause;
  logic [3:0] a_ALU_op;

  logic       b_imem_req, b_dmem_req, b_dmem_we, b_ir_write, b_pc_write, b_ALU_imm;
  logic       b_branch_enable, b_jump, b_reg_write_enable, b_trap;
  logic [2:0] b_mem_size, b_branch_cond;
  logic [1:0] b_alu_src_a, b_rd_src, b_trap_cause;
  logic [3:0] b_ALU_op;

  control_fsm #(.XLEN(32), .MEM_TIMEOUT(4), .ALU_OP_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_req(a_imem_req),
    .imem_ack(imem_ack), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_ack(dmem_ack),
    .mem_size(a_mem_size), .ir_write(a_ir_write), .pc_write(a_pc_write),
    .alu_src_a(a_alu_src_a), .ALU_imm(a_ALU_imm), .ALU_op(a_ALU_op),
    .branch_enable(a_branch_enable), .branch_cond(a_branch_cond), .jump(a_jump),
    .reg_write_enable(a_reg_write_enable), .rd_src(a_rd_src), .trap(a_trap),
    .trap_cause(a_trap_cause)
  );

  control_fsm #(.XLEN(64), .MEM_TIMEOUT(4), .ALU_OP_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_req(b_imem_req),
    .imem_ack(imem_ack), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_ack(dmem_ack),
    .mem_size(b_mem_size), .ir_write(b_ir_write), .pc_write(b_pc_write),
    .alu_src_a(b_alu_src_a), .ALU_imm(b_ALU_imm), .ALU_op(b_ALU_op),
    .branch_enable(b_branch_enable), .branch_cond(b_branch_cond), .jump(b_jump),
    .reg_write_enable(b_reg_write_enable), .rd_src(b_rd_src), .trap(b_trap),
    .trap_cause(b_trap_cause)
  );

  logic [25:0] v32, v64;
  assign v32 = {a_imem_req, a_dmem_req, a_dmem_we, a_mem_size, a_ir_write, a_pc_write,
                a_alu_src_a, a_ALU_imm, a_ALU_op, a_branch_enable, a_branch_cond, a_jump,
                a_reg_write_enable, a_rd_src, a_trap, a_trap_cause};
  assign v64 = {b_imem_req, b_dmem_req, b_dmem_we, b_mem_size, b_ir_write, b_pc_write,
                b_alu_src_a, b_ALU_imm, b_ALU_op, b_branch_enable, b_branch_cond, b_jump,
                b_reg_write_enable, b_rd_src, b_trap, b_trap_cause};

  typedef struct {
    logic        rst;
    logic        ia;
    logic        da;
    logic [31:0] rd;
    logic        sel;
    logic [25:0] exp;
    string       tag;
  } cyc_t;

  cyc_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [25:0] mk(
    input logic ireq, input logic dreq, input logic we, input logic [2:0] sz,
    input logic irw, input logic pcw, input logic [1:0] sa, input logic im,
    input logic [3:0] op, input logic be, input logic [2:0] bc, input logic j,
    input logic rwe, input logic [1:0] rs, input logic tr, input logic [1:0] c);
    return {ireq, dreq, we, sz, irw, pcw, sa, im, op, be, bc, j, rwe, rs, tr, c};
  endfunction

  function automatic logic [25:0] fe(input logic ack, input logic [1:0] c);
    return mk(1'b1, 1'b0, 1'b0, 3'd0, ack, 1'b0, 2'd0, 1'b0, OP_ADD, 1'b0, 3'd0,
              1'b0, 1'b0, 2'd0, 1'b0, c);
  endfunction

  function automatic logic [25:0] de(input logic [1:0] c);
    return mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, OP_ADD, 1'b0, 3'd0,
              1'b0, 1'b0, 2'd0, 1'b0, c);
  endfunction

  function automatic logic [25:0] ex(
    input logic pcw, input logic [1:0] sa, input logic im, input logic [3:0] op,
    input logic be, input logic [2:0] bc, input logic j, input logic rwe,
    input logic [1:0] rs, input logic [1:0] c);
    return mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, pcw, sa, im, op, be, bc, j, rwe, rs, 1'b0, c);
  endfunction

  function automatic logic [25:0] me(input logic we, input logic [2:0] sz, input logic ack,
                                     input logic [1:0] c);
    return mk(1'b0, 1'b1, we, sz, 1'b0, we & ack, 2'd0, 1'b1, OP_ADD, 1'b0, 3'd0,
              1'b0, 1'b0, 2'd0, 1'b0, c);
  endfunction

  function automatic logic [25:0] wbv(input logic [1:0] c);
    return mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0, OP_ADD, 1'b0, 3'd0,
              1'b0, 1'b1, 2'd1, 1'b0, c);
  endfunction

  function automatic logic [25:0] tp(input logic [1:0] c);
    return mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, OP_ADD, 1'b0, 3'd0,
              1'b0, 1'b0, 2'd0, 1'b1, c);
  endfunction

  task automatic push(input logic rst, input logic ia, input logic da, input logic [31:0] rd,
                      input logic sel, input logic [25:0] exp, input string tag);
    cyc_t e;
    e.rst = rst; e.ia = ia; e.da = da; e.rd = rd; e.sel = sel; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    cyc_t        e;
    logic [25:0] got;
    while (sb.size() != 0) begin
      e          = sb.pop_front();
      rst_n      = e.rst;
      imem_ack   = e.ia;
      dmem_ack   = e.da;
      imem_rdata = e.rd;
      @(negedge clk);
      got = e.sel ? v64 : v32;
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.tag, got, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_seq(input logic sel);
    push(1'b0, 1'b0, 1'b0, 32'h0, sel, 26'd0, "reset_idle");
    push(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, sel, 26'd0, "reset_inputs_active");
    push(1'b1, 1'b0, 1'b0, 32'h0, sel, 26'd0, "boot");
  endtask

  task automatic test_reset();
    reset_seq(1'b0);
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, fe(1'b0, 2'd0), "first_fetch");
    drain();
  endtask

  task automatic test_alu();
    reset_seq(1'b0);
    push(1'b1, 1'b1, 1'b0, 32'h0050_0093, 1'b0, fe(1'b1, 2'd0), "addi_fetch");
    push(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, de(2'd0), "addi_decode");
    push(1'b1, 1'b1, 1'b0, 32'h0, 1'b0,
         ex(1'b1, 2'd0, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0), "addi_exec");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, fe(1'b0, 2'd0), "addi_next_fetch_cycle5");
    drain();
  endtask

  task automatic test_load();
    reset_seq(1'b0);
    push(1'b1, 1'b1, 1'b0, 32'h0040_A103, 1'b0, fe(1'b1, 2'd0), "lw_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd0), "lw_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0,
         ex(1'b0, 2'd0, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0), "lw_exec");
    for (int i = 0; i < 3; i++)
      push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, me(1'b0, 3'b010, 1'b0, 2'd0), "lw_mem_wait");
    push(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, me(1'b0, 3'b010, 1'b1, 2'd0), "lw_mem_ack_at_limit");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, wbv(2'd0), "lw_wb");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, fe(1'b0, 2'd0), "lw_next_fetch");
    drain();
  endtask

  task automatic test_store();
    reset_seq(1'b0);
    push(1'b1, 1'b1, 1'b0, 32'h0020_A223, 1'b0, fe(1'b1, 2'd0), "sw_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd0), "sw_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0,
         ex(1'b0, 2'd0, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0), "sw_exec");
    push(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, me(1'b1, 3'b010, 1'b1, 2'd0), "sw_mem");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, fe(1'b0, 2'd0), "sw_next_fetch");
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] insn [10];
    logic [25:0] exv  [10];
    insn[0] = 32'h0020_8463; exv[0] = ex(1'b1, 2'd0, 1'b0, OP_SUB, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0);
    insn[1] = 32'h0020_9463; exv[1] = ex(1'b1, 2'd0, 1'b0, OP_SUB, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0, 2'd0);
    insn[2] = 32'h0080_00EF; exv[2] = ex(1'b1, 2'd1, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b1, 1'b1, 2'd2, 2'd0);
    insn[3] = 32'h0000_80E7; exv[3] = ex(1'b1, 2'd0, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b1, 1'b1, 2'd2, 2'd0);
    insn[4] = 32'h1234_50B7; exv[4] = ex(1'b1, 2'd2, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0);
    insn[5] = 32'h0000_1097; exv[5] = ex(1'b1, 2'd1, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0);
    insn[6] = 32'h0000_000F; exv[6] = ex(1'b1, 2'd0, 1'b0, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    insn[7] = 32'h4020_81B3; exv[7] = ex(1'b1, 2'd0, 1'b0, OP_SUB, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0);
    insn[8] = 32'h4010_D093; exv[8] = ex(1'b1, 2'd0, 1'b1, OP_SRA, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0);
    insn[9] = 32'h0FF0_F093; exv[9] = ex(1'b1, 2'd0, 1'b1, OP_AND, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0);
    reset_seq(1'b0);
    for (int i = 0; i < 10; i++) begin
      push(1'b1, 1'b1, 1'b0, insn[i], 1'b0, fe(1'b1, 2'd0), $sformatf("b2b_fetch_%0d", i));
      push(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, de(2'd0), $sformatf("b2b_decode_%0d", i));
      push(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, exv[i], $sformatf("b2b_exec_%0d", i));
    end
    drain();
  endtask

  task automatic test_traps();
    reset_seq(1'b0);
    push(1'b1, 1'b1, 1'b0, 32'h0000_0073, 1'b0, fe(1'b1, 2'd0), "ecall_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd0), "ecall_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, tp(2'd1), "ecall_trap");
    push(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, fe(1'b1, 2'd1), "ones_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd1), "ones_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, tp(2'd0), "ones_trap");
    push(1'b1, 1'b1, 1'b0, 32'h0000_B083, 1'b0, fe(1'b1, 2'd0), "ld32_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd0), "ld32_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, tp(2'd0), "ld32_trap");
    push(1'b1, 1'b1, 1'b0, 32'h0010_0073, 1'b0, fe(1'b1, 2'd0), "ebreak_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd0), "ebreak_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, tp(2'd1), "ebreak_trap");
    push(1'b1, 1'b1, 1'b0, 32'h0220_81B3, 1'b0, fe(1'b1, 2'd1), "badf7_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd1), "badf7_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, tp(2'd0), "badf7_trap");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, fe(1'b0, 2'd0), "trap_one_cycle");
    drain();
  endtask

  task automatic test_xlen64();
    reset_seq(1'b1);
    push(1'b1, 1'b1, 1'b0, 32'h0000_B083, 1'b1, fe(1'b1, 2'd0), "ld64_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, de(2'd0), "ld64_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b1,
         ex(1'b0, 2'd0, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0), "ld64_exec");
    push(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, me(1'b0, 3'b011, 1'b1, 2'd0), "ld64_mem");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, wbv(2'd0), "ld64_wb");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, fe(1'b0, 2'd0), "ld64_next_fetch");
    drain();
  endtask

  task automatic test_fetch_timeout();
    reset_seq(1'b0);
    for (int i = 0; i < 4; i++)
      push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, fe(1'b0, 2'd0), "ifetch_wait");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, tp(2'd2), "ifetch_timeout_trap");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, fe(1'b0, 2'd2), "ifetch_after_trap");
    reset_seq(1'b0);
    for (int i = 0; i < 3; i++)
      push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, fe(1'b0, 2'd0), "ifetch_wait2");
    push(1'b1, 1'b1, 1'b0, 32'h0050_0093, 1'b0, fe(1'b1, 2'd0), "ifetch_ack_at_limit");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd0), "ifetch_ack_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0,
         ex(1'b1, 2'd0, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0), "ifetch_ack_exec");
    drain();
  endtask

  task automatic test_data_timeout_and_reset();
    reset_seq(1'b0);
    push(1'b1, 1'b1, 1'b0, 32'h0020_A223, 1'b0, fe(1'b1, 2'd0), "dto_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd0), "dto_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0,
         ex(1'b0, 2'd0, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0), "dto_exec");
    for (int i = 0; i < 4; i++)
      push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, me(1'b1, 3'b010, 1'b0, 2'd0), "dto_mem_wait");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, tp(2'd3), "dto_trap");
    push(1'b1, 1'b1, 1'b0, 32'h0040_A103, 1'b0, fe(1'b1, 2'd3), "rst_lw_fetch");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, de(2'd3), "rst_lw_decode");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0,
         ex(1'b0, 2'd0, 1'b1, OP_ADD, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd3), "rst_lw_exec");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, me(1'b0, 3'b010, 1'b0, 2'd3), "rst_lw_mem_wait");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, me(1'b0, 3'b010, 1'b0, 2'd3), "rst_lw_mem_wait");
    push(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'd0, "rst_mid_mem_outputs_zero");
    push(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 26'd0, "rst_held");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'd0, "rst_release_boot");
    push(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, fe(1'b0, 2'd0), "rst_release_fetch");
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    imem_rdata = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_traps();
    test_xlen64();
    test_fetch_timeout();
    test_data_timeout_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
